// File: rtl/mult_factor_pkg.sv
// -----------------------------------------------------------------------------
// mult_factor_pkg
// Shared types and helpers for the multiplier-factorisation engine:
//   - state_e              : engine FSM states
//   - calc_p_w()           : product width for given factor widths
//   - factor_is_nontrivial : true when a factor is >= 2
// -----------------------------------------------------------------------------
package mult_factor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MUL  = 3'd2,
    ST_CMP  = 3'd3,
    ST_NEXT = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Smallest factor that counts as nontrivial; also the enumeration start.
  localparam int unsigned MIN_FACTOR = 2;

  // An A_W x B_W product always fits in A_W + B_W bits.
  function automatic int unsigned calc_p_w(input int unsigned a_w,
                                           input int unsigned b_w);
    return a_w + b_w;
  endfunction

  // Operands are zero-extended to 64 bits by the caller, so any factor width
  // up to 64 is handled by one helper.
  function automatic logic factor_is_nontrivial(input logic [63:0] v);
    return v >= 64'(MIN_FACTOR);
  endfunction

endpackage

// File: rtl/mult_shift_add.sv
// -----------------------------------------------------------------------------
// mult_shift_add
// Serial shift-add multiplier, one b bit per step, LSB first. A full product
// takes exactly B_W steps.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture a_i/b_i, clear accumulator and step counter
//   step_i     : perform one shift-add step (ignored while load_i is high)
//   a_i, b_i   : operands
//   acc_o      : running product (final after the B_W-th step)
//   last_o     : high while the current step is the last one of the product
// -----------------------------------------------------------------------------
module mult_shift_add
  import mult_factor_pkg::*;
#(
  parameter  int unsigned A_W = 8,
  parameter  int unsigned B_W = 5,
  localparam int unsigned P_W = calc_p_w(A_W, B_W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic [P_W-1:0] acc_o,
  output logic           last_o
);

  localparam int unsigned STEP_W = $clog2(B_W + 1);

  logic [P_W-1:0]    a_sh_q, a_sh_d;  // a << i for the current step i
  logic [B_W-1:0]    b_sh_q, b_sh_d;  // remaining b bits, current one at [0]
  logic [P_W-1:0]    acc_q,  acc_d;
  logic [STEP_W-1:0] step_q, step_d;

  always_comb begin
    // NOTE: every signal gets a default before the branches, so no path can
    // leave one unassigned and infer a latch.
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    acc_d  = acc_q;
    step_d = step_q;
    if (load_i) begin
      a_sh_d = P_W'(a_i);
      b_sh_d = b_i;
      acc_d  = '0;
      step_d = '0;
    end else if (step_i) begin
      if (b_sh_q[0]) begin
        acc_d = acc_q + a_sh_q;
      end
      a_sh_d = a_sh_q << 1;
      b_sh_d = b_sh_q >> 1;
      step_d = step_q + STEP_W'(1);
    end
  end

  // NOTE: the datapath registers are reset as well, so nothing derived from
  // them carries stale data out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      acc_q  <= '0;
      step_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the
      // pre-edge values regardless of statement order.
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      acc_q  <= acc_d;
      step_q <= step_d;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (step_q == STEP_W'(B_W - 1));

endmodule

// File: rtl/mult_factor_engine.sv
// -----------------------------------------------------------------------------
// mult_factor_engine
// Decides whether a (A_W bits) * b (B_W bits) == TARGET with both factors >= 2.
// Check mode : one candidate per valid/ready handshake.
// Search mode: after a start pulse, enumerates b = 2.. outer, a = 2.. inner and
//              reports the first satisfying pair or exhaustion.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : pulse, begins a search (sampled in IDLE only)
//   abort                : return to IDLE next cycle, no result
//   cand_valid/cand_ready, cand_a, cand_b : check-mode candidate handshake
//   res_valid/res_ready  : result handshake, held until accepted
//   res_sat, res_a, res_b, res_search : result payload
//   busy                 : engine not idle
//   cand_count           : candidates evaluated by the current/last search
// -----------------------------------------------------------------------------
module mult_factor_engine
  import mult_factor_pkg::*;
#(
  parameter  int unsigned A_W    = 8,
  parameter  int unsigned B_W    = 5,
  parameter  int unsigned TARGET = 307,
  localparam int unsigned P_W    = calc_p_w(A_W, B_W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic           cand_valid,
  output logic           cand_ready,
  input  logic [A_W-1:0] cand_a,
  input  logic [B_W-1:0] cand_b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           res_sat,
  output logic [A_W-1:0] res_a,
  output logic [B_W-1:0] res_b,
  output logic           res_search,
  output logic           busy,
  output logic [P_W-1:0] cand_count
);

  localparam logic [P_W-1:0] TARGET_P = P_W'(TARGET);
  localparam logic [A_W-1:0] A_FIRST  = A_W'(MIN_FACTOR);
  localparam logic [B_W-1:0] B_FIRST  = B_W'(MIN_FACTOR);
  localparam logic [A_W-1:0] A_MAX    = '1;
  localparam logic [B_W-1:0] B_MAX    = '1;

  state_e         state_q, state_d;
  logic [A_W-1:0] a_q, a_d;
  logic [B_W-1:0] b_q, b_d;
  logic           search_q, search_d;
  logic           sat_q, sat_d;
  logic [P_W-1:0] cnt_q, cnt_d;

  logic [P_W-1:0] acc;
  logic           mul_last;
  logic           mul_load;
  logic           mul_step;
  logic           cand_fire;
  logic           sat_now;
  logic           last_cand;

  assign cand_fire = cand_valid & cand_ready;
  assign sat_now   = (acc == TARGET_P)
                   & factor_is_nontrivial(64'(a_q))
                   & factor_is_nontrivial(64'(b_q));
  assign last_cand = (a_q == A_MAX) & (b_q == B_MAX);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. abort overrides everything, including res_ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_LOAD;
          end else if (cand_fire) begin
            state_d = ST_MUL;
          end
        end
        ST_LOAD: state_d = ST_MUL;
        ST_MUL:  if (mul_last) state_d = ST_CMP;
        ST_CMP: begin
          if (!search_q || sat_now || last_cand) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_NEXT;
          end
        end
        ST_NEXT: state_d = ST_MUL;
        ST_DONE: if (res_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and multiplier control
  // ---------------------------------------------------------------------------
  always_comb begin
    // rst_n gates cand_ready so every output reads 0 while reset is held.
    cand_ready = rst_n & (state_q == ST_IDLE) & ~start & ~abort;
    res_valid  = (state_q == ST_DONE);
    busy       = (state_q != ST_IDLE);
    mul_step   = (state_q == ST_MUL);
    // Every entry into MUL (from IDLE, LOAD or NEXT) restarts the multiplier
    // with the operands being registered on that same edge.
    mul_load   = (state_d == ST_MUL) & (state_q != ST_MUL);
  end

  // ---------------------------------------------------------------------------
  // Candidate registers, enumerator and search statistics
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    search_d = search_q;
    sat_d    = sat_q;
    cnt_d    = cnt_q;
    if (!abort) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_d      = A_FIRST;
            b_d      = B_FIRST;
            search_d = 1'b1;
            cnt_d    = '0;
          end else if (cand_fire) begin
            a_d      = cand_a;
            b_d      = cand_b;
            search_d = 1'b0;
          end
        end
        ST_CMP: begin
          sat_d = sat_now;
          if (search_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + P_W'(1);
          end
        end
        ST_NEXT: begin
          // b outer, a inner; a restarts at the first nontrivial value.
          if (a_q == A_MAX) begin
            a_d = A_FIRST;
            b_d = b_q + B_W'(1);
          end else begin
            a_d = a_q + A_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      search_q <= 1'b0;
      sat_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      search_q <= search_d;
      sat_q    <= sat_d;
      cnt_q    <= cnt_d;
    end
  end

  mult_shift_add #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (mul_load),
    .step_i (mul_step),
    .a_i    (a_d),
    .b_i    (b_d),
    .acc_o  (acc),
    .last_o (mul_last)
  );

  assign res_sat    = sat_q;
  assign res_a      = a_q;
  assign res_b      = b_q;
  assign res_search = search_q;
  assign cand_count = cnt_q;

endmodule

// File: tb/tb_mult_factor_engine.sv
// -----------------------------------------------------------------------------
// tb_mult_factor_engine
// Two engines share one stimulus stream: t221 (TARGET=221) and t307 (default
// TARGET=307). Expected results come from a small reference model and are
// queued when stimulus is driven; a monitor pops and compares them whenever
// a result is accepted.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mult_factor_engine;

  localparam int unsigned A_W         = 8;
  localparam int unsigned B_W         = 5;
  localparam int unsigned P_W         = A_W + B_W;
  localparam int unsigned CAND_CYCLES = B_W + 2;

  typedef struct {
    logic           sat;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           search;
    logic [P_W-1:0] count;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           abort;
  logic           cand_valid;
  logic [A_W-1:0] cand_a;
  logic [B_W-1:0] cand_b;
  logic           res_ready;

  logic           t221_cand_ready, t307_cand_ready;
  logic           t221_res_valid,  t307_res_valid;
  logic           t221_res_sat,    t307_res_sat;
  logic [A_W-1:0] t221_res_a,      t307_res_a;
  logic [B_W-1:0] t221_res_b,      t307_res_b;
  logic           t221_res_search, t307_res_search;
  logic           t221_busy,       t307_busy;
  logic [P_W-1:0] t221_cand_count, t307_cand_count;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  exp_t q221[$];
  exp_t q307[$];

  mult_factor_engine #(.A_W(A_W), .B_W(B_W), .TARGET(221)) u_t221 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cand_valid (cand_valid),
    .cand_ready (t221_cand_ready),
    .cand_a     (cand_a),
    .cand_b     (cand_b),
    .res_valid  (t221_res_valid),
    .res_ready  (res_ready),
    .res_sat    (t221_res_sat),
    .res_a      (t221_res_a),
    .res_b      (t221_res_b),
    .res_search (t221_res_search),
    .busy       (t221_busy),
    .cand_count (t221_cand_count)
  );

  mult_factor_engine #(.A_W(A_W), .B_W(B_W)) u_t307 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cand_valid (cand_valid),
    .cand_ready (t307_cand_ready),
    .cand_a     (cand_a),
    .cand_b     (cand_b),
    .res_valid  (t307_res_valid),
    .res_ready  (res_ready),
    .res_sat    (t307_res_sat),
    .res_a      (t307_res_a),
    .res_b      (t307_res_b),
    .res_search (t307_res_search),
    .busy       (t307_busy),
    .cand_count (t307_cand_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one externally supplied candidate.
  function automatic exp_t model_check(input int a, input int b, input int target);
    exp_t e;
    e.sat    = (a * b == target) && (a >= 2) && (b >= 2);
    e.a      = A_W'(a);
    e.b      = B_W'(b);
    e.search = 1'b0;
    e.count  = '0;
    return e;
  endfunction

  // Reference model: full enumeration, b outer and a inner, both from 2.
  function automatic exp_t model_search(input int target);
    exp_t e;
    int   n = 0;
    for (int b = 2; b < (1 << B_W); b++) begin
      for (int a = 2; a < (1 << A_W); a++) begin
        n++;
        if (a * b == target) begin
          e.sat = 1'b1; e.a = A_W'(a); e.b = B_W'(b);
          e.search = 1'b1; e.count = P_W'(n);
          return e;
        end
      end
    end
    e.sat = 1'b0; e.a = '1; e.b = '1; e.search = 1'b1; e.count = P_W'(n);
    return e;
  endfunction

  function automatic logic [30:0] outs221();
    return {t221_cand_ready, t221_res_valid, t221_res_sat, t221_res_a, t221_res_b,
            t221_res_search, t221_busy, t221_cand_count};
  endfunction

  function automatic logic [30:0] outs307();
    return {t307_cand_ready, t307_res_valid, t307_res_sat, t307_res_a, t307_res_b,
            t307_res_search, t307_busy, t307_cand_count};
  endfunction

  task automatic compare_result(input string name, input exp_t e, input logic sat,
                                input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                input logic search, input logic [P_W-1:0] cnt);
    check({name, "_sat"},    64'(sat),    64'(e.sat));
    check({name, "_a"},      64'(a),      64'(e.a));
    check({name, "_b"},      64'(b),      64'(e.b));
    check({name, "_search"}, 64'(search), 64'(e.search));
    if (e.search) check({name, "_count"}, 64'(cnt), 64'(e.count));
  endtask

  // Scoreboard monitor: a result is accepted on the next rising edge when
  // valid and ready are both high at the falling edge.
  exp_t m221, m307;
  always @(negedge clk) begin
    if (rst_n && res_ready && t221_res_valid) begin
      if (q221.size() == 0) check("t221_unexpected_result", 64'(q221.size()), 64'(1));
      else begin
        m221 = q221.pop_front();
        compare_result("t221", m221, t221_res_sat, t221_res_a, t221_res_b,
                       t221_res_search, t221_cand_count);
      end
    end
    if (rst_n && res_ready && t307_res_valid) begin
      if (q307.size() == 0) check("t307_unexpected_result", 64'(q307.size()), 64'(1));
      else begin
        m307 = q307.pop_front();
        compare_result("t307", m307, t307_res_sat, t307_res_a, t307_res_b,
                       t307_res_search, t307_cand_count);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit sel221, input int bound, output int n);
    n = 0;
    while (!(sel221 ? t221_res_valid : t307_res_valid) && n < bound) begin
      tick();
      n++;
    end
    check(sel221 ? "t221_result_arrives" : "t307_result_arrives",
          64'(sel221 ? t221_res_valid : t307_res_valid), 64'(1));
  endtask

  task automatic ack();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // One check-mode candidate; optionally hold the result unaccepted first.
  task automatic do_check(input int a, input int b, input int hold);
    exp_t e221;
    exp_t e307;
    int   n;
    e221 = model_check(a, b, 221);
    e307 = model_check(a, b, 307);
    q221.push_back(e221);
    q307.push_back(e307);
    cand_a     = A_W'(a);
    cand_b     = B_W'(b);
    cand_valid = 1'b1;
    @(negedge clk);
    check("cand_ready_idle", 64'({t221_cand_ready, t307_cand_ready}), 64'(2'b11));
    tick();
    cand_valid = 1'b0;
    // Handshake edge -> B_W MUL edges -> CMP edge: res_valid is up in the
    // (B_W+2)th cycle counted from the handshake cycle.
    wait_valid(1'b1, 4 * CAND_CYCLES, n);
    check("check_latency", 64'(n), 64'(B_W + 1));
    check("check_t307_valid", 64'(t307_res_valid), 64'(1));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_stable",
            64'({t221_res_valid, t221_res_sat, t221_res_a, t221_res_b, t221_res_search}),
            64'({1'b1, e221.sat, e221.a, e221.b, 1'b0}));
    end
    ack();
    check("valid_drops_after_accept", 64'({t221_res_valid, t307_res_valid}), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t s221;
    exp_t s307;
    int   n1;
    int   n2;
    logic seen;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cand_valid = 1'b0;
    res_ready = 1'b0; cand_a = '0; cand_b = '0;
    repeat (3) tick();
    check("reset_outputs_t221", 64'(outs221()), 64'(0));
    check("reset_outputs_t307", 64'(outs307()), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset",
          64'({t221_cand_ready, t307_cand_ready, t221_busy, t307_busy}), 64'(4'b1100));
    tick();

    // Check mode: hit held for 20 cycles, trivial factors, misses, extremes.
    do_check(13, 17, 20);
    do_check(221, 1, 0);
    do_check(17, 12, 0);
    do_check(17, 13, 0);
    do_check(0, 0, 0);
    do_check(255, 31, 0);

    // start and cand_valid together: the search wins, candidate not taken.
    cand_a = 8'd13; cand_b = 5'd17; cand_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    check("start_blocks_cand_ready", 64'({t221_cand_ready, t307_cand_ready}), 64'(0));
    tick();
    start = 1'b0; cand_valid = 1'b0;
    check("search_started",
          64'({t221_busy, t221_res_search, t307_busy, t307_res_search}), 64'(4'b1111));
    check("search_count_cleared", 64'(t221_cand_count), 64'(0));
    repeat (CAND_CYCLES) tick();
    check("count_after_first_cand", 64'({t221_cand_count, t307_cand_count}),
          64'({P_W'(1), P_W'(1)}));
    repeat (2) tick();  // NEXT -> MUL, one MUL step
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_to_idle",
          64'({t221_busy, t221_res_valid, t307_busy, t307_res_valid}), 64'(0));
    check("abort_keeps_count", 64'(t221_cand_count), 64'(1));
    seen = 1'b0;
    repeat (2 * CAND_CYCLES) begin
      tick();
      seen = seen | t221_res_valid | t307_res_valid | t221_busy | t307_busy;
    end
    check("no_activity_after_abort", 64'(seen), 64'(0));

    // Full searches: t221 finds a pair, t307 (prime) exhausts the space.
    s221 = model_search(221);
    s307 = model_search(307);
    q221.push_back(s221);
    q307.push_back(s307);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(1'b1, 30000, n1);
    check("search221_cycles", 64'(n1), 64'(s221.count * CAND_CYCLES));
    check("t307_still_busy", 64'(t307_busy), 64'(1));
    ack();
    wait_valid(1'b0, 60000, n2);
    check("search307_cycles", 64'(n1 + 1 + n2), 64'(s307.count * CAND_CYCLES));
    ack();
    check("search_results_accepted", 64'({t221_res_valid, t307_res_valid}), 64'(0));

    // Asynchronous reset in the middle of a search.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    check("busy_before_reset", 64'({t221_busy, t307_busy}), 64'(2'b11));
    rst_n = 1'b0;
    #1;
    check("async_reset_t221", 64'(outs221()), 64'(0));
    check("async_reset_t307", 64'(outs307()), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_after_midreset",
          64'({t221_cand_ready, t221_busy, t221_res_valid, t221_cand_count}),
          64'({3'b100, P_W'(0)}));

    check("scoreboard_t221_drained", 64'(q221.size()), 64'(0));
    check("scoreboard_t307_drained", 64'(q307.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
